// File: rtl/os_mac_pe_pkg.sv
// Shared MAC PE definitions: accumulate mode codes and parameter legality checks
// reused by the systolic array top and every PE variant.
package os_mac_pe_pkg;

  localparam int MAC_MODE_WRAP = 0;
  localparam int MAC_MODE_SAT  = 1;

  function automatic bit mult_pipe_ok(input int mult_pipe);
    return (mult_pipe == 0) || (mult_pipe == 1);
  endfunction

  function automatic bit acc_width_ok(input int data_width, input int acc_width);
    return acc_width >= 2 * data_width;
  endfunction

endpackage

// File: rtl/os_mac_pe_sat_add.sv
// Combinational (ACC_WIDTH+1)-bit add that clamps (or wraps) the sum into ACC_WIDTH bits.
// Zero latency; no flow control.
module os_mac_pe_sat_add
  import os_mac_pe_pkg::*;
#(
  parameter int ACC_WIDTH = 32,
  parameter int SATURATE  = MAC_MODE_SAT
) (
  input  logic signed [ACC_WIDTH:0]   a_i,
  input  logic signed [ACC_WIDTH:0]   b_i,
  output logic signed [ACC_WIDTH-1:0] sum_o,
  output logic                        ovf_o
);

  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic signed [ACC_WIDTH:0] raw;
  logic                      out_of_range;

  assign raw          = a_i + b_i;
  // The top two bits disagree exactly when the sum does not fit ACC_WIDTH signed bits.
  assign out_of_range = raw[ACC_WIDTH] ^ raw[ACC_WIDTH-1];

  always_comb begin
    sum_o = raw[ACC_WIDTH-1:0];
    ovf_o = 1'b0;
    if (SATURATE == MAC_MODE_SAT && out_of_range) begin
      ovf_o = 1'b1;
      sum_o = raw[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end
  end

endmodule

// File: rtl/os_mac_pe.sv
// Output-stationary MAC PE: forwards operands (1 cycle), accumulates, captures results onto
// a drain shift chain (result 1+MULT_PIPE cycles after last); no backpressure, conflicts set err.
module os_mac_pe
  import os_mac_pe_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int MULT_PIPE  = 1,
  parameter int SATURATE   = MAC_MODE_SAT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic                         in_first,
  input  logic                         in_last,
  input  logic signed [DATA_WIDTH-1:0] in_row,
  input  logic signed [DATA_WIDTH-1:0] in_col,
  output logic                         out_valid,
  output logic                         out_first,
  output logic                         out_last,
  output logic        [DATA_WIDTH-1:0] out_row,
  output logic        [DATA_WIDTH-1:0] out_col,
  input  logic                         drain_shift,
  input  logic                         drain_in_valid,
  input  logic        [ACC_WIDTH-1:0]  drain_in_data,
  output logic                         drain_out_valid,
  output logic        [ACC_WIDTH-1:0]  drain_out_data,
  output logic                         sat_flag,
  output logic                         err
);

  localparam int PW = 2 * DATA_WIDTH;

  if (!mult_pipe_ok(MULT_PIPE)) begin : g_bad_mult_pipe
    $error("os_mac_pe: MULT_PIPE must be 0 or 1");
  end
  if (!acc_width_ok(DATA_WIDTH, ACC_WIDTH)) begin : g_bad_acc_width
    $error("os_mac_pe: ACC_WIDTH must be >= 2*DATA_WIDTH");
  end

  logic                    fwd_vld_q, fwd_first_q, fwd_last_q;
  logic [DATA_WIDTH-1:0]   fwd_row_q, fwd_col_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_vld_q   <= 1'b0;
      fwd_first_q <= 1'b0;
      fwd_last_q  <= 1'b0;
      fwd_row_q   <= '0;
      fwd_col_q   <= '0;
    end else begin
      fwd_vld_q   <= in_valid;
      fwd_first_q <= in_valid & in_first;
      fwd_last_q  <= in_valid & in_last;
      if (in_valid) begin
        fwd_row_q <= in_row;
        fwd_col_q <= in_col;
      end
    end
  end

  logic signed [PW-1:0]      prod_c;
  logic signed [ACC_WIDTH:0] prod_ext_c;
  logic                      p_vld, p_first, p_last;
  logic signed [ACC_WIDTH:0] p_prod;

  assign prod_c     = PW'(in_row) * PW'(in_col);
  assign prod_ext_c = {{(ACC_WIDTH + 1 - PW){prod_c[PW-1]}}, prod_c};

  if (MULT_PIPE == 1) begin : g_mult_reg
    logic                      vld_q, first_q, last_q;
    logic signed [ACC_WIDTH:0] prod_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q   <= 1'b0;
        first_q <= 1'b0;
        last_q  <= 1'b0;
        prod_q  <= '0;
      end else begin
        vld_q   <= in_valid;
        first_q <= in_valid & in_first;
        last_q  <= in_valid & in_last;
        prod_q  <= prod_ext_c;
      end
    end
    assign p_vld   = vld_q;
    assign p_first = first_q;
    assign p_last  = last_q;
    assign p_prod  = prod_q;
  end else begin : g_mult_comb
    assign p_vld   = in_valid;
    assign p_first = in_valid & in_first;
    assign p_last  = in_valid & in_last;
    assign p_prod  = prod_ext_c;
  end

  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                        open_q, open_d;
  logic                        sat_q, sat_d;
  logic                        err_q, err_d;
  logic        [ACC_WIDTH-1:0] res_q, res_d;
  logic                        res_vld_q, res_vld_d;
  logic                        start_c, capture_c, ovf_c;
  logic signed [ACC_WIDTH:0]   base_c;
  logic signed [ACC_WIDTH-1:0] sum_c;

  // A stray non-first beat with nothing open still starts a fresh product.
  assign start_c   = p_vld & (p_first | ~open_q);
  assign capture_c = p_vld & p_last;
  assign base_c    = start_c ? '0 : {acc_q[ACC_WIDTH-1], acc_q};

  os_mac_pe_sat_add #(
    .ACC_WIDTH (ACC_WIDTH),
    .SATURATE  (SATURATE)
  ) u_sat_add (
    .a_i   (base_c),
    .b_i   (p_prod),
    .sum_o (sum_c),
    .ovf_o (ovf_c)
  );

  always_comb begin
    acc_d     = acc_q;
    open_d    = open_q;
    sat_d     = sat_q;
    err_d     = err_q;
    res_d     = res_q;
    res_vld_d = res_vld_q;
    if (p_vld) begin
      acc_d  = sum_c;
      open_d = ~p_last;
      sat_d  = start_c ? ovf_c : (sat_q | ovf_c);
      if (~p_first & ~open_q) err_d = 1'b1;
    end
    if (capture_c) begin
      res_d     = sum_c;
      res_vld_d = 1'b1;
      if (drain_shift | res_vld_q) err_d = 1'b1;
    end else if (drain_shift) begin
      res_d     = drain_in_data;
      res_vld_d = drain_in_valid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      open_q    <= 1'b0;
      sat_q     <= 1'b0;
      err_q     <= 1'b0;
      res_q     <= '0;
      res_vld_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      open_q    <= open_d;
      sat_q     <= sat_d;
      err_q     <= err_d;
      res_q     <= res_d;
      res_vld_q <= res_vld_d;
    end
  end

  assign out_valid       = fwd_vld_q;
  assign out_first       = fwd_first_q;
  assign out_last        = fwd_last_q;
  assign out_row         = fwd_row_q;
  assign out_col         = fwd_col_q;
  assign drain_out_valid = res_vld_q;
  assign drain_out_data  = res_q;
  assign sat_flag        = sat_q;
  assign err             = err_q;

endmodule

// File: tb/tb_os_mac_pe.sv
// Bench for os_mac_pe: three PE configurations share one stimulus stream and are checked
// every cycle against an arithmetic dot-product model, plus directed value checks.
module tb_os_mac_pe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_first, in_last;
  logic [7:0]  in_row, in_col;
  logic        drain_shift, drain_in_valid;
  logic [31:0] drain_in_data;

  logic        ov[3], ofst[3], olst[3], dov[3], sf[3], er[3];
  logic [7:0]  orow[3], ocol[3];
  logic [31:0] dod0;
  logic [15:0] dod1, dod2;

  always #5 clk = ~clk;

  // 0: 32-bit sat, product pipelined; 1: 16-bit sat, combinational; 2: 16-bit wrap, pipelined
  int P_AW[3]  = '{32, 16, 16};
  bit P_SAT[3] = '{1'b1, 1'b1, 1'b0};
  bit P_MP[3]  = '{1'b1, 1'b0, 1'b1};

  os_mac_pe #(.DATA_WIDTH(8), .ACC_WIDTH(32), .MULT_PIPE(1), .SATURATE(1)) u_pe0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
    .in_row(in_row), .in_col(in_col), .out_valid(ov[0]), .out_first(ofst[0]),
    .out_last(olst[0]), .out_row(orow[0]), .out_col(ocol[0]), .drain_shift(drain_shift),
    .drain_in_valid(drain_in_valid), .drain_in_data(drain_in_data),
    .drain_out_valid(dov[0]), .drain_out_data(dod0), .sat_flag(sf[0]), .err(er[0]));

  os_mac_pe #(.DATA_WIDTH(8), .ACC_WIDTH(16), .MULT_PIPE(0), .SATURATE(1)) u_pe1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
    .in_row(in_row), .in_col(in_col), .out_valid(ov[1]), .out_first(ofst[1]),
    .out_last(olst[1]), .out_row(orow[1]), .out_col(ocol[1]), .drain_shift(drain_shift),
    .drain_in_valid(drain_in_valid), .drain_in_data(drain_in_data[15:0]),
    .drain_out_valid(dov[1]), .drain_out_data(dod1), .sat_flag(sf[1]), .err(er[1]));

  os_mac_pe #(.DATA_WIDTH(8), .ACC_WIDTH(16), .MULT_PIPE(1), .SATURATE(0)) u_pe2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
    .in_row(in_row), .in_col(in_col), .out_valid(ov[2]), .out_first(ofst[2]),
    .out_last(olst[2]), .out_row(orow[2]), .out_col(ocol[2]), .drain_shift(drain_shift),
    .drain_in_valid(drain_in_valid), .drain_in_data(drain_in_data[15:0]),
    .drain_out_valid(dov[2]), .drain_out_data(dod2), .sat_flag(sf[2]), .err(er[2]));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference state: forwarded beat, plus per-PE running sum, result slot and flags.
  bit     f_v, f_f, f_l;
  longint f_r, f_c;
  longint m_acc[3], m_res[3];
  bit     m_open[3], m_rv[3], m_sat[3], m_err[3];
  bit     q_v[3], q_f[3], q_l[3];
  longint q_p[3];

  function automatic longint wrapk(input longint v, input int aw);
    return (v <<< (64 - aw)) >>> (64 - aw);
  endfunction

  task automatic model_reset();
    f_v = 0; f_f = 0; f_l = 0; f_r = 0; f_c = 0;
    for (int k = 0; k < 3; k++) begin
      m_acc[k] = 0; m_res[k] = 0; m_open[k] = 0; m_rv[k] = 0; m_sat[k] = 0; m_err[k] = 0;
      q_v[k] = 0; q_f[k] = 0; q_l[k] = 0; q_p[k] = 0;
    end
  endtask

  task automatic model_edge();
    bit     bv, bf, bl, st, clamp;
    longint bp, s, mx, mn, cur_p;
    if (rst) begin
      model_reset();
      return;
    end
    cur_p = longint'($signed(in_row)) * longint'($signed(in_col));
    for (int k = 0; k < 3; k++) begin
      if (P_MP[k]) begin
        bv = q_v[k]; bf = q_f[k]; bl = q_l[k]; bp = q_p[k];
        q_v[k] = in_valid; q_f[k] = in_first; q_l[k] = in_last; q_p[k] = cur_p;
      end else begin
        bv = in_valid; bf = in_first; bl = in_last; bp = cur_p;
      end
      s = 0;
      if (bv) begin
        st = bf || !m_open[k];
        if (!bf && !m_open[k]) m_err[k] = 1;
        s = (st ? 0 : m_acc[k]) + bp;
        mx = (longint'(1) <<< (P_AW[k] - 1)) - 1;
        mn = -(longint'(1) <<< (P_AW[k] - 1));
        clamp = 0;
        if (P_SAT[k]) begin
          if (s > mx) begin s = mx; clamp = 1; end
          else if (s < mn) begin s = mn; clamp = 1; end
        end else begin
          s = wrapk(s, P_AW[k]);
        end
        m_sat[k]  = st ? clamp : (m_sat[k] | clamp);
        m_acc[k]  = s;
        m_open[k] = !bl;
      end
      if (bv && bl) begin
        if (drain_shift || m_rv[k]) m_err[k] = 1;
        m_res[k] = s;
        m_rv[k]  = 1;
      end else if (drain_shift) begin
        m_res[k] = wrapk(longint'($signed(drain_in_data)), P_AW[k]);
        m_rv[k]  = drain_in_valid;
      end
    end
    f_v = in_valid; f_f = in_first & in_valid; f_l = in_last & in_valid;
    if (in_valid) begin
      f_r = longint'($signed(in_row));
      f_c = longint'($signed(in_col));
    end
  endtask

  task automatic check_all();
    longint dat;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0:       dat = longint'($signed(dod0));
        1:       dat = longint'($signed(dod1));
        default: dat = longint'($signed(dod2));
      endcase
      chk($sformatf("pe%0d.out_valid", k), longint'(ov[k]), longint'(f_v));
      chk($sformatf("pe%0d.out_first", k), longint'(ofst[k]), longint'(f_f));
      chk($sformatf("pe%0d.out_last", k), longint'(olst[k]), longint'(f_l));
      chk($sformatf("pe%0d.out_row", k), longint'($signed(orow[k])), f_r);
      chk($sformatf("pe%0d.out_col", k), longint'($signed(ocol[k])), f_c);
      chk($sformatf("pe%0d.drain_valid", k), longint'(dov[k]), longint'(m_rv[k]));
      chk($sformatf("pe%0d.drain_data", k), dat, m_res[k]);
      chk($sformatf("pe%0d.sat_flag", k), longint'(sf[k]), longint'(m_sat[k]));
      chk($sformatf("pe%0d.err", k), longint'(er[k]), longint'(m_err[k]));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input bit v, input bit f, input bit l, input int r, input int c,
                       input bit sh = 1'b0, input bit dv = 1'b0, input int dd = 0);
    in_valid       = v;
    in_first       = f;
    in_last        = l;
    in_row         = r[7:0];
    in_col         = c[7:0];
    drain_shift    = sh;
    drain_in_valid = dv;
    drain_in_data  = dd;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0);
      cycle();
    end
  endtask

  // Asynchronous pulse between clock edges; outputs must clear before any edge arrives.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1 model_reset();
    check_all();
    rst = 1'b0;
  endtask

  initial begin
    bit v, f, l, sh, dv;
    int r, c;
    drive(0, 0, 0, 0, 0);
    rst = 1'b1;
    model_reset();
    repeat (3) cycle();
    rst = 1'b0;

    drive(1, 0, 0, 3, -4); cycle();
    chk("fwd.row", longint'($signed(orow[0])), 3);
    chk("fwd.col", longint'($signed(ocol[0])), -4);
    chk("fwd.valid", longint'(ov[0]), 1);
    idle(2);
    chk("nofirst.err", longint'(er[0]), 1);

    drive(1, 1, 0, 5, 5); cycle();
    async_reset();
    chk("rst.err", longint'(er[0]), 0);
    chk("rst.out_valid", longint'(ov[0]), 0);

    drive(1, 1, 0, 2, 3); cycle();
    drive(1, 0, 0, -1, 5); cycle();
    drive(1, 0, 1, 4, 4); cycle();
    chk("dot.not_yet", longint'(dov[0]), 0);
    idle(1);
    chk("dot.data", longint'($signed(dod0)), 17);
    chk("dot.valid", longint'(dov[0]), 1);
    drive(0, 0, 0, 0, 0, 1, 0, 0); cycle();

    drive(1, 1, 1, 7, 7); cycle();
    idle(2);
    chk("single.data", longint'($signed(dod0)), 49);

    drive(0, 0, 0, 0, 0, 1, 1, 100); cycle();
    chk("drain.data", longint'($signed(dod0)), 100);
    chk("drain.valid1", longint'(dov[0]), 1);
    drive(0, 0, 0, 0, 0, 1, 0, 0); cycle();
    chk("drain.valid0", longint'(dov[0]), 0);

    drive(1, 1, 0, 1, 1); cycle();
    idle(1);
    drive(1, 0, 1, 1, 1); cycle();
    idle(2);
    chk("bubble.data", longint'($signed(dod0)), 2);
    drive(0, 0, 0, 0, 0, 1, 0, 0); cycle();

    drive(1, 1, 0, 127, 127); cycle();
    drive(1, 0, 0, 127, 127); cycle();
    drive(1, 0, 1, 127, 127); cycle();
    idle(2);
    chk("sat.data", longint'($signed(dod1)), 32767);
    chk("sat.flag", longint'(sf[1]), 1);
    chk("wrap.data", longint'($signed(dod2)), -17149);
    chk("wrap.flag", longint'(sf[2]), 0);
    chk("clean.err", longint'(er[0]), 0);

    async_reset();
    drive(1, 1, 0, 1, 2); cycle();
    drive(1, 0, 1, 1, 3); cycle();
    drive(0, 0, 0, 0, 0, 1, 1, 555); cycle();
    chk("conflict.data", longint'($signed(dod0)), 5);
    chk("conflict.err", longint'(er[0]), 1);

    async_reset();
    repeat (3000) begin
      v  = ($urandom_range(0, 3) != 0);
      f  = ($urandom_range(0, 5) == 0);
      l  = ($urandom_range(0, 5) == 0);
      r  = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 127 : -128)
                                       : int'($urandom_range(0, 255));
      c  = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 127 : -128)
                                       : int'($urandom_range(0, 255));
      sh = ($urandom_range(0, 3) == 0);
      dv = ($urandom_range(0, 1) == 1);
      drive(v, f, l, r, c, sh, dv, int'($urandom()));
      cycle();
      if ($urandom_range(0, 499) == 0) async_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/os_mac_pe.md
Name: os_mac_pe

Overview:
- Output-stationary integer MAC processing element, the parametrised successor of the basic systolic MAC PE.
- Forwards row/column operands with valid/first/last framing to its neighbours.
- Accumulates signed products into a wide, optionally saturating accumulator.
- Captures each finished dot product into a result register that sits on a column-wise drain shift chain.
- Tiled N×M by the systolic array top level.

Parameters:
- DATA_WIDTH, 8, signed operand width.
- ACC_WIDTH, 32, signed accumulator/result width; must be >= 2*DATA_WIDTH.
- MULT_PIPE, 1, product register stages: 0 or 1.
- SATURATE, 1, 1 = clamp accumulator to the signed ACC_WIDTH range; 0 = two's-complement wrap.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  operand beat valid.
- in_first  in  1  first beat of a dot product; qualified by in_valid.
- in_last  in  1  last beat of a dot product; qualified by in_valid.
- in_row  in  DATA_WIDTH  signed row operand.
- in_col  in  DATA_WIDTH  signed column operand.
- out_valid  out  1  registered copy of in_valid.
- out_first  out  1  registered copy of in_first.
- out_last  out  1  registered copy of in_last.
- out_row  out  DATA_WIDTH  registered copy of in_row.
- out_col  out  DATA_WIDTH  registered copy of in_col.
- drain_shift  in  1  shift the result chain by one PE.
- drain_in_valid  in  1  valid from the upstream PE result register.
- drain_in_data  in  ACC_WIDTH  data from the upstream PE result register.
- drain_out_valid  out  1  this PE's result register is occupied.
- drain_out_data  out  ACC_WIDTH  this PE's result register.
- sat_flag  out  1  sticky saturation flag for the current or last dot product.
- err  out  1  sticky protocol error flag.

Behaviour:
- Reset (async, rst=1): every register, and therefore every output, is 0; the accumulator is 0 and no dot product is open. Reset mid-operation discards the partial sum and any result.
- Forwarding, every cycle:
  - out_valid/out_first/out_last <= in_valid/in_first&in_valid/in_last&in_valid.
  - out_row/out_col load only when in_valid=1; otherwise they hold.
  - Latency is 1 cycle, independent of MULT_PIPE.
- Product: in_row*in_col is a full 2*DATA_WIDTH signed product, sign-extended to ACC_WIDTH+1.
  - MULT_PIPE=1: the product and its valid/first/last are registered once.
  - MULT_PIPE=0: the product is used combinationally.
- Accumulate, on a valid product beat:
  - first=1: acc <= prod and sat_flag cleared. A first beat during an open product silently restarts it; this is not an error.
  - else: acc <= acc + prod, computed at ACC_WIDTH+1 bits.
  - SATURATE=1: clamp to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1] and set sat_flag on clamp.
  - SATURATE=0: wrap, and sat_flag stays 0.
  - A non-first beat with no product open is treated as first=1 and sets err.
  - Invalid beats leave acc unchanged; bubbles are legal anywhere.
- Capture: on a valid product beat with last=1, the final value (the same next-acc value, including a first&last single-beat product) loads the result register and sets drain_out_valid.
  - Result visible L = 1+MULT_PIPE cycles after the in_last beat is presented.
  - The accumulator closes; the next beat must carry first.
- Drain: when drain_shift=1, result register <= drain_in_data and drain_out_valid <= drain_in_valid.
- Capture and drain_shift in the same cycle: capture wins, the upstream data is lost, and err is set.
- Capture into an occupied register with drain_shift=0: overwrite and set err.
- err and sat_flag are cleared only by rst; sat_flag is also cleared by a first beat.

Decomposition:
- Shared package: MAC mode constants (SAT/WRAP), the MULT_PIPE legal-range check, and the ACC_WIDTH >= 2*DATA_WIDTH assertion, all reused by the array top and other PE variants.
- One natural sub-module, sat_add: combinational (ACC_WIDTH+1)-bit add with clamp and overflow flag, parametrised by ACC_WIDTH and SATURATE.

Test Plan:
- Reset and forwarding: rst pulse mid-stream -> all outputs 0 immediately. Then valid beat row=3, col=-4 -> next cycle out_row=3, out_col=-4, out_valid=1.
- Dot product, MULT_PIPE=1: beats (2,3),(−1,5),(4,4) with first on beat 1 and last on beat 3 -> drain_out_data=17 and drain_out_valid=1, two cycles after the last beat.
- Bubbles and single beat: (7,7) with first&last, then an idle cycle -> result 49. (1,1),idle,(1,1) first..last -> 2.
- Saturation: ACC_WIDTH=16, DATA_WIDTH=8, repeated (127,127) ×3 -> result 32767, sat_flag=1. With SATURATE=0 -> wrapped value −17149.
- Drain chain: result 49 held, drain_in 100/valid, drain_shift=1 -> drain_out_data=100. Then drain_in_valid=0 plus shift -> drain_out_valid=0.
- Conflicts: in_last capture coincident with drain_shift -> captured value kept, err=1. Non-first beat after reset -> treated as first, err=1.
